// File: rtl/vga_sync_recover_if.sv
// Signal bundle between a VGA sync source/consumer and the sync recovery block.
// The master side drives the sample strobe and sync; the slave side returns timing and measurements.
interface vga_sync_recover_if #(
    parameter int TOTAL = 0
) ();
    localparam int CntW  = $clog2(TOTAL) + 1;
    localparam int MeasW = $clog2(TOTAL) + 2;

    logic                    enable;
    logic                    sync_in;
    logic                    locked;
    logic                    blank;
    logic                    next;
    logic signed [CntW-1:0]  counter;
    logic        [MeasW-1:0] meas_period;
    logic        [MeasW-1:0] meas_width;
    logic                    meas_valid;

    modport master (
        output enable, sync_in,
        input  locked, blank, next, counter, meas_period, meas_width, meas_valid
    );

    modport slave (
        input  enable, sync_in,
        output locked, blank, next, counter, meas_period, meas_width, meas_valid
    );
endinterface

// File: rtl/vga_sync_recover.sv
// Recovers line/frame timing from a sync stream: measures period and pulse width,
// locks after repeated conforming lines, and regenerates the transmitter's position counter.
module vga_sync_recover #(
    parameter int RESOLUTION   = 0,
    parameter int FRONT_PORCH  = 0,
    parameter int SYNC_PULSE   = 0,
    parameter int BACK_PORCH   = 0,
    parameter int TOTAL        = 0,
    parameter int POLARITY     = 0,
    parameter int LOCK_LINES   = 4,
    parameter int UNLOCK_LINES = 2
) (
    input logic               clk,
    input logic               reset_n,
    vga_sync_recover_if.slave bus
);
    localparam int CntW  = $clog2(TOTAL) + 1;
    localparam int MeasW = $clog2(TOTAL) + 2;
    localparam int LineW = $clog2(LOCK_LINES + UNLOCK_LINES + 1) + 1;

    localparam logic signed [CntW-1:0] WrapVal  = CntW'(-(FRONT_PORCH + SYNC_PULSE + BACK_PORCH));
    localparam logic signed [CntW-1:0] AlignVal = CntW'(1 - BACK_PORCH);
    localparam logic signed [CntW-1:0] LastAct  = CntW'(RESOLUTION - 1);
    localparam logic [MeasW-1:0] TimeoutPre = MeasW'(2 * TOTAL - 1);
    localparam logic [MeasW-1:0] WidthMax   = {MeasW{1'b1}};
    localparam logic [MeasW-1:0] SyncW      = MeasW'(SYNC_PULSE);
    localparam logic [MeasW-1:0] TotalW     = MeasW'(TOTAL);
    localparam logic [LineW-1:0] LockN      = LineW'(LOCK_LINES);
    localparam logic [LineW-1:0] UnlockN    = LineW'(UNLOCK_LINES);

    typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

    state_e                  state_q, state_d;
    logic                    prev_active_q, prev_active_d;
    logic        [MeasW-1:0] width_q, width_d;
    logic        [MeasW-1:0] period_q, period_d;
    logic        [MeasW-1:0] pend_period_q, pend_period_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    seen_lead_q, seen_lead_d;
    logic signed [CntW-1:0]  counter_q, counter_d;
    logic        [MeasW-1:0] meas_period_q, meas_period_d;
    logic        [MeasW-1:0] meas_width_q, meas_width_d;
    logic                    meas_valid_q, meas_valid_d;
    logic        [LineW-1:0] match_q, match_d;
    logic        [LineW-1:0] miss_q, miss_d;

    logic active, lead, trail, timeout, eval, is_match, align, next_int;

    assign active   = (POLARITY != 0) ? bus.sync_in : ~bus.sync_in;
    assign lead     = active & ~prev_active_q;
    assign trail    = ~active & prev_active_q;
    // The counter restarts after hitting 2*TOTAL so a dead input keeps producing one miss per window.
    assign timeout  = bus.enable && !lead && (period_q == TimeoutPre);
    assign eval     = bus.enable && trail && pend_valid_q && !timeout;
    assign is_match = (pend_period_q == TotalW) && (width_q == SyncW);
    assign align    = trail && (width_q == SyncW);
    assign next_int = (counter_q >= LastAct) && bus.enable;

    always_comb begin
        state_d       = state_q;
        prev_active_d = prev_active_q;
        width_d       = width_q;
        period_d      = period_q;
        pend_period_d = pend_period_q;
        pend_valid_d  = pend_valid_q;
        seen_lead_d   = seen_lead_q;
        counter_d     = counter_q;
        meas_period_d = meas_period_q;
        meas_width_d  = meas_width_q;
        meas_valid_d  = 1'b0;
        match_d       = match_q;
        miss_d        = miss_q;

        if (bus.enable) begin
            prev_active_d = active;

            if (lead) begin
                width_d = MeasW'(1);
            end else if (active && (width_q != WidthMax)) begin
                width_d = width_q + MeasW'(1);
            end

            if (lead) begin
                period_d      = MeasW'(1);
                pend_period_d = period_q;
                pend_valid_d  = seen_lead_q;
                seen_lead_d   = 1'b1;
            end else if (timeout) begin
                period_d     = '0;
                pend_valid_d = 1'b0;
            end else begin
                period_d = period_q + MeasW'(1);
            end

            if (eval) begin
                meas_period_d = pend_period_q;
                meas_width_d  = width_q;
                meas_valid_d  = 1'b1;
            end

            if (align) begin
                counter_d = AlignVal;
            end else if (next_int) begin
                counter_d = WrapVal;
            end else begin
                counter_d = counter_q + CntW'(1);
            end

            unique case (state_q)
                StSearch: begin
                    if (lead) begin
                        state_d = StCheck;
                        match_d = '0;
                    end
                end
                StCheck: begin
                    if (timeout) begin
                        state_d = StSearch;
                    end else if (eval && is_match) begin
                        if ((match_q + LineW'(1)) >= LockN) begin
                            state_d = StLocked;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + LineW'(1);
                        end
                    end else if (eval) begin
                        match_d = '0;
                    end
                end
                StLocked: begin
                    if (timeout || (eval && !is_match)) begin
                        if ((miss_q + LineW'(1)) >= UnlockN) begin
                            state_d = StSearch;
                        end else begin
                            miss_d = miss_q + LineW'(1);
                        end
                    end else if (eval) begin
                        miss_d = '0;
                    end
                end
                default: state_d = StSearch;
            endcase

            // Re-entering search forgets earlier edges so the next period starts fresh.
            if ((state_d == StSearch) && (state_q != StSearch)) begin
                seen_lead_d  = 1'b0;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StSearch;
            prev_active_q <= 1'b0;
            width_q       <= '0;
            period_q      <= '0;
            pend_period_q <= '0;
            pend_valid_q  <= 1'b0;
            seen_lead_q   <= 1'b0;
            counter_q     <= WrapVal;
            meas_period_q <= '0;
            meas_width_q  <= '0;
            meas_valid_q  <= 1'b0;
            match_q       <= '0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            prev_active_q <= prev_active_d;
            width_q       <= width_d;
            period_q      <= period_d;
            pend_period_q <= pend_period_d;
            pend_valid_q  <= pend_valid_d;
            seen_lead_q   <= seen_lead_d;
            counter_q     <= counter_d;
            meas_period_q <= meas_period_d;
            meas_width_q  <= meas_width_d;
            meas_valid_q  <= meas_valid_d;
            match_q       <= match_d;
            miss_q        <= miss_d;
        end
    end

    assign bus.locked      = (state_q == StLocked);
    assign bus.blank       = (state_q != StLocked) || counter_q[CntW-1];
    assign bus.next        = next_int;
    assign bus.counter     = counter_q;
    assign bus.meas_period = meas_period_q;
    assign bus.meas_width  = meas_width_q;
    assign bus.meas_valid  = meas_valid_q;
endmodule
